irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  External interrupt front-end feeding the interrupts[7:0] input of coprocessor0.
//  - Synchronises up to 7 asynchronous IRQ pins and detects edges or levels per line.
//  - Holds per-line pending bits, gates them with an enable mask and drives a registered vector.
//  - Bit 7 is driven 0; cop0 substitutes its timer-pending bit there.
//  - Software configures the block through a small word-addressed MMIO register window.
// PARAMETERS
//  NIRQ         7   number of external IRQ lines (1..7); drives interrupts[NIRQ-1:0]
//  SYNC_STAGES  2   synchroniser flops per line (>=2)
// PORTS
//  clk         in   1     system clock; single clock domain
//  reset       in   1     synchronous, active-high reset
//  irq_in      in   NIRQ  asynchronous IRQ pins, active-high
//  we          in   1     MMIO write strobe, one cycle per write
//  addr        in   2     MMIO word address (0..3)
//  wdata       in   32    MMIO write data
//  rdata       out  32    MMIO read data, combinational on addr
//  interrupts  out  8     to cop0 interrupts[7:0]; bits 7..NIRQ tied 0
// BEHAVIOUR
//  Register map (bits above NIRQ-1 read 0, write ignored):
//  - 0 PENDING  RO / W1C. W1C acts on edge-mode lines only.
//  - 1 ENABLE   RW. Reset value 0.
//  - 2 MODE     RW. 1 = edge (rising), 0 = level. Reset value 0.
//  - 3 RAW      RO. Synchronised irq_in. Writes ignored.
//  Reset values: sync chain, prev, pending, enable, mode and interrupts are all 0.
//  Synchroniser and edge detect:
//  - s = last synchroniser stage.
//  - prev <= s each cycle.
//  - rise = s & ~prev.
//  Pending update, every cycle:
//  - Level line: pending[i] <= s[i].
//  - Edge line: pending[i] <= rise[i] | (pending[i] & ~clr[i]).
//  - clr = we & (addr==0) & wdata[i].
//  - A rise and a W1C on the same line in the same cycle leave pending = 1 (set wins).
//  Output register:
//  - interrupts[i] <= pending[i] & enable[i].
//  - ENABLE and MODE writes take effect on the next clock edge.
//  Latency:
//  - irq_in change to interrupts change = SYNC_STAGES+2 cycles (4 at default).
//  - ENABLE write to interrupts change = 2 cycles.
//  Pending is independent of ENABLE:
//  - Edges arriving while a line is disabled are latched.
//  - Setting ENABLE later raises the output.
//  Mode switches:
//  - edge->level: pending follows s from the next cycle.
//  - level->edge: pending keeps its current value until W1C.
//  Reset mid-operation:
//  - All state clears, including prev.
//  - A pin still high after reset produces exactly one rise once synchronised.
//  - This is required: no lost interrupt.
//  Repeated edges before W1C coalesce into one pending bit; no counting.
//  Pulses shorter than one clk period may be missed; this is documented, not detected.
//  rdata: {zeros, reg[NIRQ-1:0]} for the addressed register; no read side effects.
// STRUCTURE
//  Package irq_pkg:
//  - localparams IRQ_ADDR_PENDING=0, IRQ_ADDR_ENABLE=1, IRQ_ADDR_MODE=2, IRQ_ADDR_RAW=3.
//  - IRQ_LINES_MAX=7.
//  Sub-module irq_sync (parameter SYNC_STAGES):
//  - One line: synchroniser chain, prev flop and rise output.
//  - Instantiated NIRQ times through a generate loop.
//  Top level holds the MMIO registers, pending logic, output register and read mux.
// TESTING
//  1. Reset, then read all registers -> every rdata = 0; interrupts = 8'h00.
//  2. MODE=0, ENABLE=7'h01, irq_in[0]=1 at cycle t:
//     -> interrupts[0]=1 at t+4; drop irq_in -> interrupts[0]=0 four cycles later.
//  3. MODE=7'h04, ENABLE=7'h04, pulse irq_in[2] for 3 cycles:
//     -> PENDING reads 7'h04 and stays; write PENDING=7'h04 -> interrupts[2]=0 two cycles later.
//  4. Edge line 2 pending, W1C in the same cycle as a new rise -> PENDING bit 2 remains 1.
//  5. ENABLE=0, edge on line 5 -> PENDING=7'h20, interrupts=0;
//     write ENABLE=7'h20 -> interrupts[5]=1 two cycles after the write.
//  6. irq_in[1] held high in edge mode, reset asserted 3 cycles then released:
//     -> pending[1] sets exactly once; interrupts[7] is always 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt front-end.
// Holds the MMIO word addresses of the register window and the maximum
// number of external lines that fit below cop0's timer bit (interrupts[7]).
package irq_pkg;

  localparam logic [1:0] IRQ_ADDR_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_ADDR_MODE    = 2'd2;
  localparam logic [1:0] IRQ_ADDR_RAW     = 2'd3;

  localparam int IRQ_LINES_MAX = 7;

endpackage

// File: rtl/irq_sync.sv
// Single-line synchroniser with rising-edge detect.
// Ports:
//   clk      in  1  system clock
//   reset    in  1  synchronous active-high reset (clears chain and prev)
//   irq_in   in  1  asynchronous IRQ pin
//   sync_out out 1  last synchroniser stage (s)
//   rise     out 1  s & ~prev, one cycle per synchronised rising edge
// Clearing prev on reset means a pin still high afterwards yields exactly
// one rise once it has propagated through the chain.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchroniser shift chain and previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_r[SYNC_STAGES-1];
  assign rise     = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/irq_controller.sv
// External interrupt front-end feeding cop0 interrupts[7:0].
// Synchronises NIRQ pins, latches edge- or level-mode pending bits, gates
// them with an enable mask and drives a registered vector. Bit 7 and any
// bits at or above NIRQ are tied 0 (cop0 owns bit 7 for its timer).
// Ports:
//   clk        in  1     system clock
//   reset      in  1     synchronous active-high reset
//   irq_in     in  NIRQ  asynchronous active-high IRQ pins
//   we         in  1     MMIO write strobe
//   addr       in  2     MMIO word address: 0 PENDING, 1 ENABLE, 2 MODE, 3 RAW
//   wdata      in  32    MMIO write data
//   rdata      out 32    MMIO read data, combinational on addr
//   interrupts out 8     registered interrupt vector to cop0
module irq_controller
  import irq_pkg::*;
#(
  parameter int NIRQ        = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [7:0]      interrupts
);

  logic [NIRQ-1:0] sync_s;
  logic [NIRQ-1:0] rise_s;
  logic [NIRQ-1:0] clr_s;
  logic [NIRQ-1:0] pending_nxt_s;
  logic [NIRQ-1:0] pending_r;
  logic [NIRQ-1:0] enable_r;
  logic [NIRQ-1:0] mode_r;
  logic [NIRQ-1:0] int_vec_r;

  // Upper write-data bits have no register behind them.
  logic unused_wdata_s;
  assign unused_wdata_s = ^wdata[31:NIRQ];

  for (genvar g = 0; g < NIRQ; g++) begin : g_line
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in[g]),
      .sync_out(sync_s[g]),
      .rise    (rise_s[g])
    );
  end

  // W1C mask and next pending value; a rise beats a same-cycle clear.
  always_comb begin
    clr_s = {NIRQ{1'b0}};
    if (we && (addr == IRQ_ADDR_PENDING)) begin
      clr_s = wdata[NIRQ-1:0];
    end else begin
      clr_s = {NIRQ{1'b0}};
    end
    pending_nxt_s = (mode_r & (rise_s | (pending_r & ~clr_s))) |
                    (~mode_r & sync_s);
  end

  // Pending bits and gated output vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {NIRQ{1'b0}};
      int_vec_r <= {NIRQ{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      int_vec_r <= pending_r & enable_r;
    end
  end

  // ENABLE and MODE software registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r <= {NIRQ{1'b0}};
      mode_r   <= {NIRQ{1'b0}};
    end else if (we && (addr == IRQ_ADDR_ENABLE)) begin
      enable_r <= wdata[NIRQ-1:0];
    end else if (we && (addr == IRQ_ADDR_MODE)) begin
      mode_r   <= wdata[NIRQ-1:0];
    end
  end

  // Read mux, no side effects.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      IRQ_ADDR_PENDING: rdata[NIRQ-1:0] = pending_r;
      IRQ_ADDR_ENABLE:  rdata[NIRQ-1:0] = enable_r;
      IRQ_ADDR_MODE:    rdata[NIRQ-1:0] = mode_r;
      IRQ_ADDR_RAW:     rdata[NIRQ-1:0] = sync_s;
      default:          rdata = 32'd0;
    endcase
  end

  assign interrupts = {{(8-NIRQ){1'b0}}, int_vec_r};

endmodule
